shift_rows_stream: RTL

Streaming, parametrised ShiftRows/InvShiftRows engine for the Rijndael datapath. It accepts one state block per cycle over a valid/ready handshake and applies forward shift, inverse shift or bypass per transaction. Block width is selected by NB, so the same unit serves AES-128 and wider-block Rijndael variants. The result is registered and placed behind a 2-entry skid buffer so that `in_ready` has no combinational path from `out_ready`. It sits between SubBytes/InvSubBytes and MixColumns/InvMixColumns in the round pipeline.

---
 rtl/shift_rows_stream.sv | 132 +++++++++++++
 1 files changed

// File: rtl/shift_rows_stream.sv
// Purpose : streaming Rijndael ShiftRows / InvShiftRows / bypass engine, NB = 4, 6 or 8 columns.
// Latency : 1 cycle from accept to out_valid; sustains 1 block/cycle while out_ready is high.
// Backpressure: a 2-entry skid (output reg + skid reg) holds blocks; in_ready = ~skid_valid_q (flop only).
// Ports   : clk/n_rst (async active-low), in_valid/in_ready/in_data/in_mode upstream,
//           out_valid/out_ready/out_data/out_err downstream, clr_count/blk_count delivered-block counter.
module shift_rows_stream #(
  parameter int NB = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [32*NB-1:0] in_data,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*NB-1:0] out_data,
  output logic            out_err,
  input  logic            clr_count,
  output logic [15:0]     blk_count
);

  localparam int W = 32 * NB;

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_stream: NB must be 4, 6 or 8");
    end
  endgenerate

  // Byte (r,c) lives at [W-1-8*(4c+r) -: 8]; all indices are elaboration constants.
  logic [W-1:0] fwd_data;
  logic [W-1:0] inv_data;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // The 8-column variant skips offset 2 on the lower two rows.
      localparam int OFF   = (NB == 8 && r >= 2) ? r + 1 : r;
      localparam int DST   = W - 1 - 8 * (4 * c + r);
      localparam int SRC_F = W - 1 - 8 * (4 * ((c + OFF) % NB) + r);
      localparam int SRC_I = W - 1 - 8 * (4 * ((c + NB - OFF) % NB) + r);
      assign fwd_data[DST -: 8] = in_data[SRC_F -: 8];
      assign inv_data[DST -: 8] = in_data[SRC_I -: 8];
    end
  end

  logic [W-1:0] xf_data;
  logic         xf_err;

  always_comb begin
    xf_data = in_data;
    xf_err  = 1'b0;
    case (in_mode)
      2'b01:   xf_data = fwd_data;
      2'b10:   xf_data = inv_data;
      2'b11:   xf_err  = 1'b1;
      default: xf_data = in_data;
    endcase
  end

  logic [W-1:0] out_data_q, out_data_d;
  logic         out_err_q, out_err_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         skid_err_q, skid_err_d;
  logic         skid_valid_q, skid_valid_d;
  logic [15:0]  blk_count_q, blk_count_d;
  logic         accept;
  logic         pop;

  always_comb begin
    accept       = in_valid & ~skid_valid_q;
    pop          = out_valid_q & out_ready;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    skid_valid_d = skid_valid_q;

    if (skid_valid_q && pop) begin
      // in_ready is low while the skid is full, so no accept can coincide.
      out_data_d   = skid_data_q;
      out_err_d    = skid_err_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!out_valid_q || pop)) begin
      out_data_d  = xf_data;
      out_err_d   = xf_err;
      out_valid_d = 1'b1;
    end else if (accept) begin
      skid_data_d  = xf_data;
      skid_err_d   = xf_err;
      skid_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    blk_count_d = blk_count_q;
    if (clr_count) begin
      blk_count_d = 16'h0000;
    end else if (pop && blk_count_q != 16'hFFFF) begin
      blk_count_d = blk_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      blk_count_q  <= 16'h0000;
    end else begin
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      skid_valid_q <= skid_valid_d;
      blk_count_q  <= blk_count_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign blk_count = blk_count_q;

endmodule
